// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller: width codes, FSM encoding, byte enables.
// Also holds the start-qualification rule so the controller and any future users agree on it.
package mem_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Exactly one of read/write, a width legal for that direction, and natural alignment.
  function automatic logic access_ok(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [1:0] a);
    logic legal;
    logic aligned;
    legal   = 1'b0;
    aligned = 1'b0;
    case (f3)
      F3_B:  begin legal = 1'b1; aligned = 1'b1;        end
      F3_H:  begin legal = 1'b1; aligned = ~a[0];       end
      F3_W:  begin legal = 1'b1; aligned = (a == 2'b00); end
      F3_BU: begin legal = rd;   aligned = 1'b1;        end
      F3_HU: begin legal = rd;   aligned = ~a[0];       end
      default: ;
    endcase
    return (rd ^ wr) & legal & aligned;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: store byte enables / data replication, load lane select and extension.
// No state; the store side sees live EX/MA fields, the load side sees the latched access.
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  st_func_3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_func_3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    st_be    = BE_NONE;
    st_wdata = st_data;
    case (st_func_3)
      F3_B, F3_BU: begin
        st_be    = BE_BYTE0 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      F3_H, F3_HU: begin
        st_be    = st_addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        st_wdata = {2{st_data[15:0]}};
      end
      F3_W:    st_be = BE_WORD;
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
    half_sel = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_func_3)
      F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ld_data = {24'd0, byte_sel};
      F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ld_data = {16'd0, half_sel};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_controller.sv
// Memory-stage controller: qualifies loads/stores, runs one req/ack transaction, extends load data.
// Stall is raised combinationally on start and held through ACCESS; DONE releases the pipeline.
module mem_access_controller
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  func_3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault,
  output logic        timeout
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        to_q, to_d;
  logic        fault_q, fault_d;

  logic        start;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_ld;

  mem_lane_align u_align (
    .st_func_3  (func_3),
    .st_addr_lo (addr[1:0]),
    .st_data    (store_data),
    .st_be      (al_be),
    .st_wdata   (al_wdata),
    .ld_func_3  (f3_q),
    .ld_addr_lo (addr_q[1:0]),
    .ld_rdata   (rdata_q),
    .ld_data    (al_ld)
  );

  assign start      = access_ok(mem_read, mem_write, func_3, addr[1:0]);
  assign dmem_we    = we_q;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign fault      = fault_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    f3_d       = f3_q;
    rdata_d    = rdata_q;
    to_d       = to_q;
    fault_d    = 1'b0;
    stall      = 1'b0;
    dmem_req   = 1'b0;
    load_valid = 1'b0;
    load_data  = 32'd0;
    timeout    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        to_d  = 1'b0;
        if (start) begin
          stall   = 1'b1;
          addr_d  = addr;
          we_d    = mem_write;
          be_d    = al_be;
          wdata_d = al_wdata;
          f3_d    = func_3;
          state_d = ST_ACCESS;
        end else if (mem_read | mem_write) begin
          fault_d = 1'b1;
        end
      end
      ST_ACCESS: begin
        stall    = 1'b1;
        dmem_req = 1'b1;
        cnt_d    = cnt_q + 8'd1;
        // An ack on the final allowed cycle still wins over the timeout.
        if (dmem_ack) begin
          rdata_d = dmem_rdata;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          to_d    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (to_q) begin
          timeout = 1'b1;
        end else if (!we_q) begin
          load_valid = 1'b1;
          load_data  = al_ld;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      rdata_q <= 32'd0;
      to_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      to_q    <= to_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_mem_access_controller.sv
// Self-checking bench for mem_access_controller: directed scenarios plus randomized accesses
// compared against an arithmetic reference model of the access rules.
module tb_mem_access_controller;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  func_3 = 3'd0;
  logic [31:0] addr = 32'd0, store_data = 32'd0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata = 32'd0;
  logic        dmem_ack = 1'b0;
  logic        stall, load_valid, fault, timeout;
  logic [31:0] load_data;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_access_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .mem_read(mem_read), .mem_write(mem_write), .func_3(func_3),
    .addr(addr), .store_data(store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall(stall), .load_data(load_data),
    .load_valid(load_valid), .fault(fault), .timeout(timeout)
  );

  // ---------------- reference model (access rules as arithmetic) ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_start(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (rd && (f3 == 3'd4 || f3 == 3'd5));
    return (rd != wr) && legal && ((int'(a[1:0]) % m_size(f3)) == 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int mask;
    mask = ((1 << m_size(f3)) - 1) << int'(a[1:0]);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (m_size(f3) == 1) return 32'(d[7:0]) * 32'h0101_0101;
    if (m_size(f3) == 2) return 32'(d[15:0]) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
    longint v, span;
    int s;
    s    = m_size(f3);
    span = longint'(1) << (8 * s);
    v    = (longint'(r) >> (8 * int'(a[1:0]))) % span;
    if (!f3[2] && s < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // ---------------- observations from one access ----------------
  int          o_stall, o_req, o_lv, o_fault, o_to;
  bit          o_first_stall, o_unstable, o_ld_nz_to, o_done;
  logic [31:0] o_addr, o_wdata, o_ld;
  logic [3:0]  o_be;
  logic        o_we;

  // Holds the instruction in EX/MA while stalled, acks after `waits` ACCESS cycles,
  // then clears the inputs for `tail` cycles to catch delayed pulses.
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] rdat, input int waits, input int tail);
    int acc = 0;
    int tail_left = 0;
    o_stall = 0; o_req = 0; o_lv = 0; o_fault = 0; o_to = 0;
    o_first_stall = 0; o_unstable = 0; o_ld_nz_to = 0; o_done = 0;
    o_addr = '0; o_wdata = '0; o_ld = '0; o_be = '0; o_we = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge CLK);
      if (!o_done) begin
        mem_read = rd; mem_write = wr; func_3 = f3; addr = a; store_data = sd;
      end else begin
        mem_read = 1'b0; mem_write = 1'b0; func_3 = 3'($urandom); addr = $urandom; store_data = $urandom;
      end
      dmem_ack   = dmem_req && (acc == waits);
      dmem_rdata = dmem_ack ? rdat : $urandom;
      #1;
      if (cyc == 0) o_first_stall = stall;
      if (stall) o_stall++;
      if (dmem_req) begin
        if (o_req == 0) begin
          o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata; o_we = dmem_we;
        end else if (dmem_addr !== o_addr || dmem_be !== o_be || dmem_wdata !== o_wdata || dmem_we !== o_we) begin
          o_unstable = 1;
        end
        o_req++;
        acc++;
      end
      if (load_valid) begin o_lv++; o_ld = load_data; end
      if (timeout) begin o_to++; if (load_data !== 32'd0) o_ld_nz_to = 1; end
      if (fault) o_fault++;
      if (o_done) begin
        tail_left--;
        if (tail_left <= 0) break;
      end else if (!stall) begin
        o_done = 1;
        tail_left = tail;
        if (tail == 0) break;
      end
    end
    dmem_ack = 1'b0;
    checks++;
    if (!o_done) begin
      errors++;
      $display("FAIL access_budget: stall never released within 400 cycles, required release");
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    checks += 6;
    if (dmem_req !== 1'b0)    begin errors++; $display("FAIL reset_req: got %b need 0", dmem_req); end
    if (stall !== 1'b0)       begin errors++; $display("FAIL reset_stall: got %b need 0", stall); end
    if ({dmem_we, dmem_be} !== 5'd0) begin errors++; $display("FAIL reset_we_be: got %b need 0", {dmem_we, dmem_be}); end
    if (dmem_addr !== 32'd0 || dmem_wdata !== 32'd0) begin errors++; $display("FAIL reset_addr_wdata: got %h/%h need 0/0", dmem_addr, dmem_wdata); end
    if (load_data !== 32'd0 || load_valid !== 1'b0) begin errors++; $display("FAIL reset_load: got %h/%b need 0/0", load_data, load_valid); end
    if (fault !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_pulses: got fault=%b timeout=%b need 0/0", fault, timeout); end
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic test_store_word();
    run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 1);
    checks += 6;
    if (o_first_stall !== 1'b1) begin errors++; $display("FAIL sw_stall_same_cycle: got %b need 1", o_first_stall); end
    if (o_stall != 2)           begin errors++; $display("FAIL sw_stall_cycles: got %0d need 2", o_stall); end
    if (o_be !== 4'b1111)       begin errors++; $display("FAIL sw_be: got %b need 1111", o_be); end
    if (o_addr !== 32'h100)     begin errors++; $display("FAIL sw_addr: got %h need 00000100", o_addr); end
    if (o_wdata !== 32'hDEAD_BEEF || o_we !== 1'b1) begin errors++; $display("FAIL sw_wdata_we: got %h/%b need deadbeef/1", o_wdata, o_we); end
    if (o_lv != 0)              begin errors++; $display("FAIL sw_no_load_valid: got %0d need 0", o_lv); end
  endtask

  task automatic test_store_byte();
    run_access(1'b0, 1'b1, 3'b000, 32'h203, 32'h0000_00A5, 32'h0, 1, 1);
    checks += 4;
    if (o_be !== 4'b1000)       begin errors++; $display("FAIL sb_be: got %b need 1000", o_be); end
    if (o_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata: got %h need a5a5a5a5", o_wdata); end
    if (o_addr !== 32'h200)     begin errors++; $display("FAIL sb_addr: got %h need 00000200", o_addr); end
    if (o_stall != 3)           begin errors++; $display("FAIL sb_stall_cycles: got %0d need 3", o_stall); end
  endtask

  task automatic test_load_byte();
    run_access(1'b1, 1'b0, 3'b000, 32'h301, 32'h0, 32'h0000_8000, 3, 1);
    checks += 4;
    if (o_ld !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h need ffffff80", o_ld); end
    if (o_lv != 1)              begin errors++; $display("FAIL lb_valid_pulses: got %0d need 1", o_lv); end
    if (o_stall != 5)           begin errors++; $display("FAIL lb_stall_cycles: got %0d need 5", o_stall); end
    if (o_addr !== 32'h300 || o_we !== 1'b0) begin errors++; $display("FAIL lb_addr_we: got %h/%b need 00000300/0", o_addr, o_we); end
    run_access(1'b1, 1'b0, 3'b100, 32'h301, 32'h0, 32'h0000_8000, 3, 1);
    checks += 2;
    if (o_ld !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data: got %h need 00000080", o_ld); end
    if (o_lv != 1)              begin errors++; $display("FAIL lbu_valid_pulses: got %0d need 1", o_lv); end
    run_access(1'b1, 1'b0, 3'b001, 32'h302, 32'h0, 32'h9234_5678, 0, 1);
    checks++;
    if (o_ld !== 32'hFFFF_9234) begin errors++; $display("FAIL lh_upper_data: got %h need ffff9234", o_ld); end
  endtask

  task automatic test_fault();
    logic [2:0]  f3s [5] = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b010};
    logic [31:0] as  [5] = '{32'h103, 32'h102, 32'h100, 32'h100, 32'h100};
    bit          rds [5] = '{1, 1, 0, 1, 1};
    bit          wrs [5] = '{0, 0, 1, 0, 1};
    for (int i = 0; i < 5; i++) begin
      run_access(rds[i], wrs[i], f3s[i], as[i], 32'h1234_5678, 32'h0, 0, 2);
      checks += 3;
      if (o_fault != 1) begin errors++; $display("FAIL fault_pulse[%0d]: got %0d need 1", i, o_fault); end
      if (o_req != 0)   begin errors++; $display("FAIL fault_no_req[%0d]: got %0d need 0", i, o_req); end
      if (o_stall != 0) begin errors++; $display("FAIL fault_no_stall[%0d]: got %0d need 0", i, o_stall); end
    end
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'hFFFF_FFFF, 1000, 1);
    checks += 5;
    if (o_req != TO)      begin errors++; $display("FAIL to_req_cycles: got %0d need %0d", o_req, TO); end
    if (o_stall != TO + 1) begin errors++; $display("FAIL to_stall_cycles: got %0d need %0d", o_stall, TO + 1); end
    if (o_to != 1)        begin errors++; $display("FAIL to_pulse: got %0d need 1", o_to); end
    if (o_lv != 0)        begin errors++; $display("FAIL to_no_load_valid: got %0d need 0", o_lv); end
    if (o_ld_nz_to)       begin errors++; $display("FAIL to_load_data_zero: got nonzero need 0"); end
  endtask

  task automatic test_back_to_back();
    run_access(0, 1, 3'b010, 32'h600, 32'h1111_1111, 32'h0, 0, 0);
    run_access(1, 0, 3'b101, 32'h602, 32'h0, 32'h8765_4321, 0, 0);
    checks += 3;
    if (o_first_stall !== 1'b1) begin errors++; $display("FAIL b2b_immediate_start: got %b need 1", o_first_stall); end
    if (o_stall != 2)           begin errors++; $display("FAIL b2b_stall_cycles: got %0d need 2", o_stall); end
    if (o_ld !== 32'h0000_8765 || o_lv != 1) begin errors++; $display("FAIL b2b_lhu_data: got %h/%0d need 00008765/1", o_ld, o_lv); end
  endtask

  task automatic test_reset_mid_access();
    int bad = 0;
    @(negedge CLK);
    mem_read = 1'b1; mem_write = 1'b0; func_3 = 3'b010; addr = 32'h500;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (dmem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req_before: got %b need 1", dmem_req); end
    @(negedge CLK);
    RESET_N = 1'b0; mem_read = 1'b0;
    @(negedge CLK);
    #1;
    checks += 2;
    if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req_dropped: got %b need 0", dmem_req); end
    if (stall !== 1'b0)    begin errors++; $display("FAIL rst_mid_stall: got %b need 0", stall); end
    RESET_N = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge CLK);
    dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (load_valid !== 1'b0 || dmem_req !== 1'b0 || timeout !== 1'b0) bad++;
      @(negedge CLK);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_late_ack_ignored: got %0d bad cycles need 0", bad); end
    run_access(0, 1, 3'b010, 32'h700, 32'h5555_AAAA, 32'h0, 0, 1);
    checks++;
    if (o_stall != 2 || o_addr !== 32'h700) begin errors++; $display("FAIL rst_recover: got stall=%0d addr=%h need 2/00000700", o_stall, o_addr); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 120; n++) begin
      bit rd, wr, st, timed;
      logic [2:0] f3;
      logic [31:0] a, sd, rdat;
      int waits, acc_cycles;
      int pick = $urandom_range(0, 9);
      rd = (pick < 5) || (pick == 9);
      wr = (pick >= 5);
      if (pick == 0) begin rd = 0; wr = 0; end
      f3 = (n % 3 == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)) | (rd ? {$urandom_range(0, 1) == 1, 2'b00} : 3'b000);
      a = $urandom; sd = $urandom; rdat = $urandom;
      waits = $urandom_range(0, 5);
      run_access(rd, wr, f3, a, sd, rdat, waits, 2);
      st = m_start(rd, wr, f3, a);
      timed = st && (waits >= TO);
      acc_cycles = !st ? 0 : (timed ? TO : waits + 1);
      checks += 5;
      if (o_fault != ((rd || wr) && !st ? 1 : 0)) begin errors++; $display("FAIL rnd_fault[%0d]: got %0d need %0d", n, o_fault, (rd || wr) && !st); end
      if (o_req != acc_cycles) begin errors++; $display("FAIL rnd_req_cycles[%0d]: got %0d need %0d", n, o_req, acc_cycles); end
      if (o_stall != (st ? acc_cycles + 1 : 0)) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d need %0d", n, o_stall, st ? acc_cycles + 1 : 0); end
      if (o_lv != ((st && rd && !timed) ? 1 : 0)) begin errors++; $display("FAIL rnd_load_valid[%0d]: got %0d", n, o_lv); end
      if (o_to != (timed ? 1 : 0)) begin errors++; $display("FAIL rnd_timeout[%0d]: got %0d need %0d", n, o_to, timed); end
      if (st) begin
        checks += 2;
        if (o_addr !== {a[31:2], 2'b00} || o_we !== wr) begin errors++; $display("FAIL rnd_addr_we[%0d]: got %h/%b need %h/%b", n, o_addr, o_we, {a[31:2], 2'b00}, wr); end
        if (o_unstable) begin errors++; $display("FAIL rnd_stable[%0d]: dmem outputs changed during request", n); end
      end
      if (st && wr) begin
        checks++;
        if (o_be !== m_be(f3, a) || o_wdata !== m_wdata(f3, sd)) begin errors++; $display("FAIL rnd_store[%0d]: got be=%b wd=%h need be=%b wd=%h", n, o_be, o_wdata, m_be(f3, a), m_wdata(f3, sd)); end
      end
      if (st && rd && !timed) begin
        checks++;
        if (o_ld !== m_load(f3, a, rdat)) begin errors++; $display("FAIL rnd_load[%0d]: got %h need %h (f3=%b a=%h r=%h)", n, o_ld, m_load(f3, a, rdat), f3, a, rdat); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_byte();
    test_fault();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
